// File: rtl/jack_sprite_fetch_pkg.sv
// Shared definitions for the blue-character sprite path (fetch front end and renderer).
package jack_pkg;

   localparam int SPR_W = 47;
   localparam int SPR_H = 60;
   localparam int RGB_W = 12;

   localparam logic [RGB_W-1:0] KEY_COLOR = 12'h000;

   // spr_state bit positions
   localparam int ST_RIGHT = 0;
   localparam int ST_AIR   = 1;
   localparam int ST_MOVE  = 2;

   typedef logic [RGB_W-1:0] rgb_t;

   // Per-pixel side information that rides alongside the ROM fetch
   typedef struct packed {
      logic hit;
      logic valid;
      rgb_t bg;
   } align_t;

endpackage

// File: rtl/jack_sprite_fetch_if.sv
// Scan-side, character-state and renderer signals of the sprite fetch front end.
interface jack_sprite_fetch_if;
   import jack_pkg::*;

   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_valid;
   logic        frame_start;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        dir_right;
   logic        in_air;
   logic        moving;
   rgb_t        bg_pix;
   rgb_t        spr_pix;
   logic [13:0] spr_addr;
   logic [2:0]  spr_state;
   logic [31:0] ipcnt;
   rgb_t        rgb_out;
   logic        rgb_valid;

   // Fetch block side
   modport slave (
      input  pix_x, pix_y, pix_valid, frame_start,
      input  pos_x, pos_y, dir_right, in_air, moving,
      input  bg_pix, spr_pix,
      output spr_addr, spr_state, ipcnt, rgb_out, rgb_valid
   );

   // Scan generator / renderer side
   modport master (
      output pix_x, pix_y, pix_valid, frame_start,
      output pos_x, pos_y, dir_right, in_air, moving,
      output bg_pix, spr_pix,
      input  spr_addr, spr_state, ipcnt, rgb_out, rgb_valid
   );

endinterface

// File: rtl/jack_sprite_fetch_pipe_delay.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module pipe_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift one stage per clock; reset empties every stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/jack_sprite_fetch.sv
// Sprite fetch front end: frame-latched hit test and ROM addressing, delay-aligned
// colour-key composite, and a free-running animation tick counter.
module jack_sprite_fetch
   import jack_pkg::*;
#(
   parameter int          ROM_LAT  = 2,
   parameter int unsigned TICK_DIV = 6000001
) (
   input  logic         clk,
   input  logic         rst_n,
   jack_sprite_fetch_if.slave bus
);

   logic [9:0]  lx_q, lx_d;
   logic [9:0]  ly_q, ly_d;
   logic [2:0]  state_q, state_d;
   logic [13:0] addr_q, addr_d;
   logic [31:0] ipcnt_q, ipcnt_d;
   rgb_t        rgb_q, rgb_d;
   logic        rgb_valid_q, rgb_valid_d;

   logic        hit;
   logic [10:0] x_end, y_end;
   logic [9:0]  dx, dy;
   align_t      align_in, align_out;

   // Position/state captured only at frame start so the character never tears
   always_comb begin
      lx_d    = lx_q;
      ly_d    = ly_q;
      state_d = state_q;
      if (bus.frame_start) begin
         lx_d              = bus.pos_x;
         ly_d              = bus.pos_y;
         state_d[ST_RIGHT] = bus.dir_right;
         state_d[ST_AIR]   = bus.in_air;
         state_d[ST_MOVE]  = bus.moving;
      end
   end

   // Hit test in 11 bits so a sprite at the right/bottom edge cannot wrap to column/row 0
   always_comb begin
      x_end = {1'b0, lx_q} + 11'(SPR_W);
      y_end = {1'b0, ly_q} + 11'(SPR_H);
      hit   = bus.pix_valid
              && ({1'b0, bus.pix_x} >= {1'b0, lx_q}) && ({1'b0, bus.pix_x} < x_end)
              && ({1'b0, bus.pix_y} >= {1'b0, ly_q}) && ({1'b0, bus.pix_y} < y_end);
      dx     = bus.pix_x - lx_q;
      dy     = bus.pix_y - ly_q;
      addr_d = hit ? (14'(dy) * 14'(SPR_W) + 14'(dx)) : 14'd0;
   end

   // Animation tick wraps at TICK_DIV-1
   always_comb begin
      ipcnt_d = (ipcnt_q == 32'(TICK_DIV - 1)) ? 32'd0 : ipcnt_q + 32'd1;
   end

   assign align_in = '{hit: hit, valid: bus.pix_valid, bg: bus.bg_pix};

   pipe_delay #(
      .WIDTH ($bits(align_t)),
      .DEPTH (1 + ROM_LAT)
   ) u_align (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (align_in),
      .q_o   (align_out)
   );

   // Sprite pixel wins unless it carries the transparent key colour
   always_comb begin
      rgb_d       = (align_out.hit && (bus.spr_pix != KEY_COLOR)) ? bus.spr_pix : align_out.bg;
      rgb_valid_d = align_out.valid;
   end

   // State registers for latch, address, tick counter and composite output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lx_q        <= '0;
         ly_q        <= '0;
         state_q     <= 3'b001;
         addr_q      <= '0;
         ipcnt_q     <= '0;
         rgb_q       <= '0;
         rgb_valid_q <= 1'b0;
      end else begin
         lx_q        <= lx_d;
         ly_q        <= ly_d;
         state_q     <= state_d;
         addr_q      <= addr_d;
         ipcnt_q     <= ipcnt_d;
         rgb_q       <= rgb_d;
         rgb_valid_q <= rgb_valid_d;
      end
   end

   assign bus.spr_addr  = addr_q;
   assign bus.spr_state = state_q;
   assign bus.ipcnt     = ipcnt_q;
   assign bus.rgb_out   = rgb_q;
   assign bus.rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_jack_sprite_fetch.sv
// Directed bench for jack_sprite_fetch with a short tick modulus.
module tb_jack_sprite_fetch;
   import jack_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   int   cyc;

   jack_sprite_fetch_if bus ();

   jack_sprite_fetch #(
      .ROM_LAT  (2),
      .TICK_DIV (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic scan(input int x, input int y, input logic v, input logic [11:0] bg);
      bus.pix_x     = 10'(x);
      bus.pix_y     = 10'(y);
      bus.pix_valid = v;
      bus.bg_pix    = bg;
   endtask

   task automatic frame(input int x, input int y, input logic r, input logic a, input logic m);
      bus.frame_start = 1'b1;
      bus.pos_x       = 10'(x);
      bus.pos_y       = 10'(y);
      bus.dir_right   = r;
      bus.in_air      = a;
      bus.moving      = m;
   endtask

   // Present one pixel, then idle until its composite appears four clocks later
   task automatic composite(input int x, input int y, input logic [11:0] bg,
                            input logic [11:0] spr, input logic [11:0] exp_rgb, input string tag);
      bus.spr_pix = spr;
      scan(x, y, 1'b1, bg);
      step();
      scan(0, 0, 1'b0, 12'h000);
      step();
      step();
      step();
      chk({tag, "_rgb"}, 32'(bus.rgb_out), 32'(exp_rgb));
      chk({tag, "_vld"}, 32'(bus.rgb_valid), 32'd1);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      rst_n  = 1'b0;
      bus.frame_start = 1'b0;
      bus.pos_x = '0; bus.pos_y = '0;
      bus.dir_right = 1'b0; bus.in_air = 1'b0; bus.moving = 1'b0;
      bus.spr_pix = '0;
      scan(0, 0, 1'b0, 12'h000);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr",  32'(bus.spr_addr),  32'd0);
      chk("rst_state", 32'(bus.spr_state), 32'd1);
      chk("rst_rgb",   32'(bus.rgb_out),   32'd0);
      chk("rst_vld",   32'(bus.rgb_valid), 32'd0);
      chk("rst_ipcnt", bus.ipcnt,          32'd0);

      rst_n = 1'b1;
      cyc   = 0;

      // Frame latch: state 3'b001 before, 3'b100 one clock after
      frame(100, 200, 1'b0, 1'b0, 1'b1);
      chk("state_pre", 32'(bus.spr_state), 32'd1);
      step();
      bus.frame_start = 1'b0;
      chk("state_post", 32'(bus.spr_state), 32'd4);
      chk("ipcnt_1", bus.ipcnt, 32'd1);

      // Address corners and misses just past the box
      scan(100, 200, 1'b1, 12'h000); step(); chk("addr_tl", 32'(bus.spr_addr), 32'd0);
      scan(146, 259, 1'b1, 12'h000); step(); chk("addr_br", 32'(bus.spr_addr), 32'd2819);
      scan(147, 200, 1'b1, 12'h000); step(); chk("miss_x",  32'(bus.spr_addr), 32'd0);
      scan(146, 259, 1'b1, 12'h000); step(); chk("addr_br2", 32'(bus.spr_addr), 32'd2819);
      scan(100, 260, 1'b1, 12'h000); step(); chk("miss_y",  32'(bus.spr_addr), 32'd0);
      scan(101, 201, 1'b0, 12'h000); step(); chk("novalid", 32'(bus.spr_addr), 32'd0);
      chk("ipcnt_wrap", bus.ipcnt, 32'(cyc % 4));

      // Composite: opaque sprite, key colour, and a miss with opaque sprite
      composite(101, 200, 12'h0AB, 12'hF00, 12'hF00, "opaque");
      step();
      chk("vld_drop", 32'(bus.rgb_valid), 32'd0);
      composite(101, 200, 12'h0AB, 12'h000, 12'h0AB, "keyed");
      composite(300, 300, 12'h123, 12'hF00, 12'h123, "miss");

      // Right-edge sprite: 11-bit sums keep x=5 outside
      frame(620, 0, 1'b1, 1'b1, 1'b0);
      step();
      bus.frame_start = 1'b0;
      chk("state_edge", 32'(bus.spr_state), 32'd3);
      scan(639, 0, 1'b1, 12'h000); step(); chk("edge_hit", 32'(bus.spr_addr), 32'd19);
      scan(5, 0, 1'b1, 12'h000);   step(); chk("edge_nowrap", 32'(bus.spr_addr), 32'd0);

      // pos_x changed without frame_start is ignored
      bus.pos_x = 10'd0;
      scan(639, 0, 1'b1, 12'h000); step(); chk("hold_lx", 32'(bus.spr_addr), 32'd19);

      // frame_start coincident with a pixel: that pixel still sees lx=620
      frame(0, 0, 1'b0, 1'b0, 1'b0);
      scan(1, 0, 1'b1, 12'h000);   step(); chk("coinc_old", 32'(bus.spr_addr), 32'd0);
      bus.frame_start = 1'b0;
      scan(1, 0, 1'b1, 12'h000);   step(); chk("coinc_new", 32'(bus.spr_addr), 32'd1);
      chk("ipcnt_mid", bus.ipcnt, 32'(cyc % 4));

      // Tick sequence over a full wrap
      for (int i = 0; i < 5; i++) begin
         step();
         chk("ipcnt_seq", bus.ipcnt, 32'(cyc % 4));
      end

      // Fill the pipeline, then reset asynchronously mid-cycle
      bus.spr_pix = 12'hF00;
      scan(3, 3, 1'b1, 12'h0AB);
      repeat (4) step();
      chk("fill_vld", 32'(bus.rgb_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ipcnt", bus.ipcnt,          32'd0);
      chk("arst_vld",   32'(bus.rgb_valid), 32'd0);
      chk("arst_addr",  32'(bus.spr_addr),  32'd0);
      chk("arst_state", 32'(bus.spr_state), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("flush_vld", 32'(bus.rgb_valid), 32'd0);
      end
      step();
      chk("refill_vld", 32'(bus.rgb_valid), 32'd1);
      chk("refill_rgb", 32'(bus.rgb_out),   32'h0F00);
      chk("ipcnt_post", bus.ipcnt,          32'(cyc % 4));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/jack_sprite_fetch.md
# jack_sprite_fetch

Front end of the blue-character sprite path, sitting between the VGA scan generator and the sprite renderer. It turns the current scan coordinate and the character's position and motion flags into a sprite ROM address, a 3-bit state word and an animation counter for the renderer. It then takes the renderer's pixel back, applies colour-key transparency over the background, and emits a latency-aligned composited pixel. Position and state are sampled once per video frame so the character never tears mid-frame.

## Interface
- SPR_W, 47: sprite width in pixels (ROM row stride).
- SPR_H, 60: sprite height in pixels.
- ROM_LAT, 2: cycles from `spr_addr` to a valid `spr_pix` (renderer ROM plus its output register).
- KEY_COLOR, 12'h000: transparent colour.
- TICK_DIV, 6000001: `ipcnt` modulus.

- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_x  in  10  scan column
- pix_y  in  10  scan row
- pix_valid  in  1  active-video qualifier for `pix_x`/`pix_y`
- frame_start  in  1  one-cycle pulse at frame start (vsync)
- pos_x  in  10  character top-left column
- pos_y  in  10  character top-left row
- dir_right  in  1  1 = facing right
- in_air  in  1  1 = airborne
- moving  in  1  1 = walking
- bg_pix  in  12  background RGB444, aligned with `pix_x`/`pix_y`
- spr_pix  in  12  renderer output
- spr_addr  out  14  sprite ROM address
- spr_state  out  3  bit0 = right, bit1 = air, bit2 = move
- ipcnt  out  32  animation tick counter
- rgb_out  out  12  composited pixel
- rgb_valid  out  1  `rgb_out` qualifier

## Operation
- **Frame latch**
  - On `frame_start`, register `pos_x`, `pos_y` and {`moving`, `in_air`, `dir_right`} into `lx`, `ly` and `spr_state`.
  - The values are held until the next `frame_start`.
  - If `frame_start` and `pix_valid` are both high in the same cycle, that pixel uses the old latched values.
- **Hit test**
  - hit = `pix_valid` && `pix_x` >= `lx` && `pix_x` < `lx`+SPR_W && `pix_y` >= `ly` && `pix_y` < `ly`+SPR_H.
  - Sums are formed in 11 bits, so a sprite at the screen edge cannot wrap.
- **Address**
  - On hit: `spr_addr` = (`pix_y`-`ly`)*SPR_W + (`pix_x`-`lx`), registered.
  - On miss: `spr_addr` = 0.
  - The address is always the unmirrored one; mirroring is the renderer's job.
- **Alignment**
  - hit, `pix_valid` and `bg_pix` pass through a 1+ROM_LAT stage delay line so they meet `spr_pix`.
- **Composite** (registered):
  - `rgb_out` = (hit_d && `spr_pix` != KEY_COLOR) ? `spr_pix` : bg_d.
  - `rgb_valid` = valid_d.
- **Tick counter**
  - `ipcnt` increments every cycle and wraps from TICK_DIV-1 to 0.
  - It is free-running and independent of frames.

## Timing
- Reset values:
  - `spr_addr` = 0, `rgb_out` = 0, `rgb_valid` = 0, `ipcnt` = 0.
  - `spr_state` = 3'b001 (right, ground, stand).
  - `lx` = `ly` = 0.
  - All delay-line stages = 0.
- Latencies:
  - Scan input to `spr_addr`: 1 cycle.
  - Scan input to `rgb_out`/`rgb_valid`: ROM_LAT+2 cycles (4 at default).
  - `frame_start` to `spr_state`/`lx`/`ly` update: 1 cycle.
- Reset asserted mid-line flushes the pipeline.
  - After `rst_n` rises, `rgb_valid` stays 0 until real valid pixels have traversed all ROM_LAT+2 stages.
- No backpressure; one pixel accepted per clock.

## Structure
- Shared package `jack_pkg` holds:
  - SPR_W, SPR_H, KEY_COLOR.
  - State bit indices ST_RIGHT=0, ST_AIR=1, ST_MOVE=2.
  - The RGB444 width.
  - The renderer uses the same package.
- One sub-module: `pipe_delay` (parameters WIDTH, DEPTH, async active-low clear), instantiated for the {hit, valid, bg} bundle.

## Test plan
- Reset release, then `frame_start` with pos=(100,200) and `dir_right`=0, `in_air`=0, `moving`=1.
  - Required: one cycle later `spr_state`=3'b100.
  - Before that `frame_start`, `spr_state`=3'b001.
- Latched pos=(100,200), scan (100,200) → `spr_addr`=0; scan (146,259) → `spr_addr`=2819.
  - Required: scan (147,200) and (100,260) → miss, `spr_addr`=0.
- Hit pixel with `spr_pix`=12'hF00, `bg_pix`=12'h0AB → `rgb_out`=12'hF00 four cycles later.
  - Required: with `spr_pix`=12'h000 instead → `rgb_out`=12'h0AB.
- pos=(620,0), scan x=639 → hit, `spr_addr`=19.
  - Required: scan x=5 → miss (no 10-bit wrap).
- `pos_x` changed mid-frame without `frame_start` → addresses keep using the old `lx`.
  - Required: a `frame_start` coincident with a valid pixel applies from the next pixel.
- TICK_DIV=4 → `ipcnt` sequence 0,1,2,3,0.
  - Required: `rst_n` pulsed low asynchronously mid-stream → `ipcnt`=0 and `rgb_valid`=0 immediately.
